// File: rtl/word_delivery.sv
// Word source for the typing game: a 16-word ROM indexed by an LFSR.
// Advances to a different word on each synchronised rising edge of wordComplete.
module word_delivery #(
  parameter int          NUM_WORDS = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wordComplete,
  output logic [19:0] currentWord
);

  localparam logic [4:0] L_A = 5'd0;
  localparam logic [4:0] L_B = 5'd1;
  localparam logic [4:0] L_C = 5'd2;
  localparam logic [4:0] L_D = 5'd3;
  localparam logic [4:0] L_E = 5'd4;
  localparam logic [4:0] L_F = 5'd5;
  localparam logic [4:0] L_G = 5'd6;
  localparam logic [4:0] L_H = 5'd7;
  localparam logic [4:0] L_I = 5'd8;
  localparam logic [4:0] L_J = 5'd9;
  localparam logic [4:0] L_K = 5'd10;
  localparam logic [4:0] L_L = 5'd11;
  localparam logic [4:0] L_M = 5'd12;
  localparam logic [4:0] L_N = 5'd13;
  localparam logic [4:0] L_O = 5'd14;
  localparam logic [4:0] L_P = 5'd15;
  localparam logic [4:0] L_R = 5'd17;
  localparam logic [4:0] L_S = 5'd18;
  localparam logic [4:0] L_T = 5'd19;
  localparam logic [4:0] L_U = 5'd20;
  localparam logic [4:0] L_W = 5'd22;
  localparam logic [4:0] L_Y = 5'd24;
  localparam logic [4:0] L_Z = 5'd25;

  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  // Letter 1 lands in the low bits so it is typed first.
  function automatic logic [19:0] wd(
    input logic [4:0] l1,
    input logic [4:0] l2,
    input logic [4:0] l3,
    input logic [4:0] l4
  );
    return {l4, l3, l2, l1};
  endfunction

  function automatic logic [19:0] rom(input logic [3:0] idx);
    logic [19:0] w;
    w = wd(L_C, L_O, L_D, L_E);
    case (idx)
      4'd0:  w = wd(L_C, L_O, L_D, L_E);
      4'd1:  w = wd(L_G, L_A, L_T, L_E);
      4'd2:  w = wd(L_W, L_I, L_R, L_E);
      4'd3:  w = wd(L_C, L_H, L_I, L_P);
      4'd4:  w = wd(L_B, L_I, L_T, L_S);
      4'd5:  w = wd(L_B, L_Y, L_T, L_E);
      4'd6:  w = wd(L_F, L_L, L_O, L_P);
      4'd7:  w = wd(L_N, L_A, L_N, L_D);
      4'd8:  w = wd(L_L, L_O, L_O, L_P);
      4'd9:  w = wd(L_P, L_O, L_R, L_T);
      4'd10: w = wd(L_B, L_A, L_N, L_K);
      4'd11: w = wd(L_D, L_A, L_T, L_A);
      4'd12: w = wd(L_F, L_I, L_F, L_O);
      4'd13: w = wd(L_H, L_A, L_L, L_T);
      4'd14: w = wd(L_J, L_U, L_M, L_P);
      4'd15: w = wd(L_Z, L_E, L_R, L_O);
      default: w = wd(L_C, L_O, L_D, L_E);
    endcase
    return w;
  endfunction

  logic [7:0]  r_lfsr;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [3:0]  r_index;
  logic [19:0] r_word;

  logic        w_fb;
  logic        w_adv;
  logic [3:0]  w_cand;
  logic [3:0]  w_inc;
  logic [3:0]  w_next_idx;

  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_adv = r_s2 & ~r_s3;

  always_comb begin
    w_cand     = r_lfsr[3:0];
    w_inc      = (r_index == LAST_IDX) ? 4'd0 : r_index + 4'd1;
    w_next_idx = w_cand;
    // Never repeat the current word.
    if (w_cand == r_index) begin
      w_next_idx = w_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr  <= LFSR_SEED;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_index <= 4'd0;
      r_word  <= wd(L_C, L_O, L_D, L_E);
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      r_s1   <= wordComplete;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      if (w_adv) begin
        r_index <= w_next_idx;
        r_word  <= rom(w_next_idx);
      end
    end
  end

  assign currentWord = r_word;

endmodule

// File: tb/tb_word_delivery.sv
// Directed self-checking bench for word_delivery.
// Tracks the LFSR and current index to predict each advance.
module tb_word_delivery;

  localparam logic [7:0]  SEED = 8'hA5;
  localparam logic [19:0] CODE = 20'h20DC2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wordComplete = 1'b0;
  logic [19:0] currentWord;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_lfsr = SEED;
  logic [3:0] m_idx = 4'd0;

  string names [16] = '{
    "CODE", "GATE", "WIRE", "CHIP",
    "BITS", "BYTE", "FLOP", "NAND",
    "LOOP", "PORT", "BANK", "DATA",
    "FIFO", "HALT", "JUMP", "ZERO"
  };

  word_delivery #(
    .NUM_WORDS(16),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wordComplete(wordComplete),
    .currentWord(currentWord)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] enc(input string s);
    logic [19:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[5*i +: 5] = 5'(s[i] - 8'd65);
    end
    return w;
  endfunction

  function automatic logic [7:0] lstep(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [3:0] pick(
    input logic [7:0] l,
    input logic [3:0] idx
  );
    logic [3:0] c;
    c = l[3:0];
    if (c == idx) c = idx + 4'd1;
    return c;
  endfunction

  function automatic bit in_rom(input logic [19:0] w);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (enc(names[i]) == w) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) m_lfsr = lstep(m_lfsr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wordComplete = 1'b0;
    m_lfsr = SEED;
    m_idx = 4'd0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] prev;
    int changes;
    reset = 1'b0;
    wordComplete = 1'b0;
    m_lfsr = SEED;
    m_idx = 4'd0;
    repeat (3) tick();
    checks++;
    if (currentWord !== CODE) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", currentWord, CODE);
    end
    reset = 1'b1;
    prev = currentWord;
    changes = 0;
    repeat (50) begin
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
    end
    checks++;
    if (changes !== 0) begin
      failures++;
      $display("FAIL reset_stable changes=%0d exp=0", changes);
    end
    checks++;
    if (currentWord !== CODE) begin
      failures++;
      $display("FAIL reset_word got=%h exp=%h", currentWord, CODE);
    end
    checks++;
    if (dut.r_lfsr !== m_lfsr) begin
      failures++;
      $display("FAIL reset_lfsr50 got=%h exp=%h", dut.r_lfsr, m_lfsr);
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_l [3];
    exp_l = '{8'h4A, 8'h95, 8'h2A};
    do_reset();
    checks++;
    if (dut.r_lfsr !== SEED) begin
      failures++;
      $display("FAIL lfsr_seed got=%h exp=%h", dut.r_lfsr, SEED);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut.r_lfsr !== exp_l[i]) begin
        failures++;
        $display("FAIL lfsr_step%0d got=%h exp=%h", i, dut.r_lfsr, exp_l[i]);
      end
    end
  endtask

  task automatic test_single_advance();
    logic [3:0] e;
    int changes;
    logic [19:0] prev;
    do_reset();
    repeat (5) tick();
    wordComplete = 1'b1;
    tick();
    checks++;
    if (currentWord !== CODE) begin
      failures++;
      $display("FAIL single_early1 got=%h exp=%h", currentWord, CODE);
    end
    tick();
    checks++;
    if (currentWord !== CODE) begin
      failures++;
      $display("FAIL single_early2 got=%h exp=%h", currentWord, CODE);
    end
    e = pick(m_lfsr, m_idx);
    tick();
    checks++;
    if (currentWord !== enc(names[e])) begin
      failures++;
      $display("FAIL single_word got=%h exp=%h", currentWord, enc(names[e]));
    end
    checks++;
    if (currentWord === CODE) begin
      failures++;
      $display("FAIL single_not_idx0 got=%h exp=!%h", currentWord, CODE);
    end
    m_idx = e;
    tick();
    wordComplete = 1'b0;
    prev = currentWord;
    changes = 0;
    repeat (10) begin
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
    end
    checks++;
    if (changes !== 0) begin
      failures++;
      $display("FAIL single_after changes=%0d exp=0", changes);
    end
  endtask

  task automatic test_held_high();
    logic [3:0] e;
    logic [19:0] prev;
    int changes;
    e = m_idx;
    wordComplete = 1'b1;
    prev = currentWord;
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 2) e = pick(m_lfsr, m_idx);
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
    end
    checks++;
    if (changes !== 1) begin
      failures++;
      $display("FAIL held_changes got=%0d exp=1", changes);
    end
    checks++;
    if (currentWord !== enc(names[e])) begin
      failures++;
      $display("FAIL held_word got=%h exp=%h", currentWord, enc(names[e]));
    end
    m_idx = e;
    wordComplete = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    logic [19:0] prev;
    logic [19:0] last;
    int changes;
    bit bad_letter;
    changes = 0;
    prev = currentWord;
    for (int p = 0; p < 20; p++) begin
      last = currentWord;
      wordComplete = 1'b1;
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
      e = pick(m_lfsr, m_idx);
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
      checks++;
      if (currentWord !== enc(names[e])) begin
        failures++;
        $display("FAIL b2b_word p=%0d got=%h exp=%h",
                 p, currentWord, enc(names[e]));
      end
      checks++;
      if (currentWord === last) begin
        failures++;
        $display("FAIL b2b_repeat p=%0d got=%h prev=%h", p, currentWord, last);
      end
      checks++;
      if (!in_rom(currentWord)) begin
        failures++;
        $display("FAIL b2b_in_rom p=%0d got=%h", p, currentWord);
      end
      bad_letter = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (currentWord[5*i +: 5] == 5'h1F) bad_letter = 1'b1;
      end
      checks++;
      if (bad_letter) begin
        failures++;
        $display("FAIL b2b_letter p=%0d got=%h exp=no_1F", p, currentWord);
      end
      m_idx = e;
      wordComplete = 1'b0;
      repeat (3) begin
        tick();
        if (currentWord !== prev) changes++;
        prev = currentWord;
      end
    end
    checks++;
    if (changes !== 20) begin
      failures++;
      $display("FAIL b2b_changes got=%0d exp=20", changes);
    end
  endtask

  task automatic test_reset_mid_advance();
    logic [19:0] prev;
    int changes;
    wordComplete = 1'b1;
    tick();
    reset = 1'b0;
    wordComplete = 1'b0;
    m_lfsr = SEED;
    m_idx = 4'd0;
    #1;
    checks++;
    if (currentWord !== CODE) begin
      failures++;
      $display("FAIL mid_async got=%h exp=%h", currentWord, CODE);
    end
    repeat (2) tick();
    reset = 1'b1;
    prev = currentWord;
    changes = 0;
    repeat (10) begin
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
    end
    checks++;
    if (changes !== 0 || currentWord !== CODE) begin
      failures++;
      $display("FAIL mid_no_adv changes=%0d got=%h exp=%h",
               changes, currentWord, CODE);
    end
    checks++;
    if (dut.r_lfsr !== m_lfsr) begin
      failures++;
      $display("FAIL mid_lfsr got=%h exp=%h", dut.r_lfsr, m_lfsr);
    end
  endtask

  task automatic test_reset_vs_adv();
    logic [19:0] prev;
    int changes;
    wordComplete = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wordComplete = 1'b0;
    m_lfsr = SEED;
    m_idx = 4'd0;
    repeat (2) tick();
    checks++;
    if (currentWord !== CODE) begin
      failures++;
      $display("FAIL rva_hold got=%h exp=%h", currentWord, CODE);
    end
    reset = 1'b1;
    prev = currentWord;
    changes = 0;
    repeat (10) begin
      tick();
      if (currentWord !== prev) changes++;
      prev = currentWord;
    end
    checks++;
    if (changes !== 0) begin
      failures++;
      $display("FAIL rva_no_adv changes=%0d exp=0", changes);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_single_advance();
    test_held_high();
    test_back_to_back();
    test_reset_mid_advance();
    test_reset_vs_adv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
